// File: rtl/audio_pkg.sv
// Shared audio constants: default sample divider, covox control-byte fields and reset value.
package audio_pkg;

  localparam int unsigned RATE_DIV_DEF  = 1000;
  localparam int unsigned CTL_FIFO_MODE = 7;
  localparam int unsigned CTL_RATE_HI   = 1;
  localparam int unsigned CTL_RATE_LO   = 0;
  localparam logic [7:0]  COVOX_RESET   = 8'h00;

  // Reload value of the sample divider for a given rate selection.
  function automatic int unsigned period_m1(input int unsigned rate_div, input logic [1:0] rate_sel);
    return (rate_div << rate_sel) - 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous 8-bit sample FIFO with read-ahead head output and occupancy from extended pointers.
module sample_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointer bookkeeping; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == PW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/covox_fifo.sv
// Covox sample source: queues CPU writes and releases one per divider tick, or passes writes
// straight through in legacy direct mode.
module covox_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned RATE_DIV   = RATE_DIV_DEF,
  parameter int unsigned DIV_W      = 13
) (
  input  logic                  clk24,
  input  logic                  reset,
  input  logic                  i_wr,
  input  logic [7:0]            i_data,
  input  logic                  i_ctl_wr,
  input  logic [7:0]            i_ctl_data,
  output logic [7:0]            covox,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overrun,
  output logic                  o_underrun
);

  logic             fifo_mode;
  logic [1:0]       rate_sel;
  logic [DIV_W-1:0] div;
  logic [7:0]       head;
  logic             tick_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic             under_c;
  logic             unused_ctl;

  assign unused_ctl = ^i_ctl_data[6:2];

  // A control write overrides any coincident data write or tick.
  always_comb begin
    tick_c  = (div == '0);
    pop_c   = 1'b0;
    push_c  = 1'b0;
    drop_c  = 1'b0;
    under_c = 1'b0;
    if (fifo_mode && !i_ctl_wr) begin
      pop_c   = tick_c && !o_empty;
      under_c = tick_c && o_empty;
      push_c  = i_wr && (!o_full || pop_c);
      drop_c  = i_wr && o_full && !pop_c;
    end
  end

  sample_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk24),
    .reset (reset),
    .flush (i_ctl_wr),
    .push  (push_c),
    .pop   (pop_c),
    .din   (i_data),
    .dout  (head),
    .level (o_level),
    .full  (o_full),
    .empty (o_empty)
  );

  always_ff @(posedge clk24) begin
    if (reset) begin
      fifo_mode  <= 1'b0;
      rate_sel   <= 2'd0;
      div        <= '0;
      covox      <= COVOX_RESET;
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
    end else if (i_ctl_wr) begin
      fifo_mode  <= i_ctl_data[CTL_FIFO_MODE];
      rate_sel   <= i_ctl_data[CTL_RATE_HI:CTL_RATE_LO];
      div        <= DIV_W'(period_m1(RATE_DIV, i_ctl_data[CTL_RATE_HI:CTL_RATE_LO]));
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      div <= tick_c ? DIV_W'(period_m1(RATE_DIV, rate_sel)) : div - DIV_W'(1);
      if (drop_c)  o_overrun  <= 1'b1;
      if (under_c) o_underrun <= 1'b1;
      if (pop_c)
        covox <= head;
      else if (!fifo_mode && i_wr)
        covox <= i_data;
    end
  end

endmodule
